// File: rtl/stripes_pkg.sv
// Shared types and constants for the Stripes bit-serial feeder.
package stripes_pkg;

    localparam int COL_BITS = 3;
    localparam int NUM_COLS = 8;

    localparam int DEF_DATA_WIDTH   = 8;
    localparam int DEF_VEC_LENGTH   = 16;
    localparam int DEF_RESULT_WIDTH = 3 * DEF_DATA_WIDTH;
    localparam int DEF_ACC_WIDTH    = 3 * DEF_DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/stripes_next_column.sv
// Finds the lowest non-zero weight bit column strictly above col; none_left when none remains.
module stripes_next_column
    import stripes_pkg::*;
(
    input  logic [NUM_COLS-1:0] mask,
    input  logic [COL_BITS-1:0] col,
    output logic [COL_BITS-1:0] next_col,
    output logic                none_left
);

    // Scanning downwards lets the lowest qualifying column win.
    always_comb begin
        next_col  = col;
        none_left = 1'b1;
        for (int i = NUM_COLS - 1; i >= 0; i--) begin
            if ((i > int'(col)) && mask[i]) begin
                next_col  = COL_BITS'(i);
                none_left = 1'b0;
            end
        end
    end

endmodule

// File: rtl/stripes_bit_serial_feeder.sv
// Weight-side feeder for the Stripes bit-serial MAC: serialises weights LSB-first, sums column results.
// Build option ZERO_COLUMN_SKIP_EN: all-zero weight bit columns are not issued.
//
// state | meaning
// IDLE  | waiting for an input vector, in_ready high
// ISSUE | driving one weight bit column per cycle to the MAC
// DRAIN | absorbing the last registered column result
// DONE  | dot product presented on out_data until out_ready
module stripes_bit_serial_feeder
    import stripes_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int VEC_LENGTH   = DEF_VEC_LENGTH,
    parameter int RESULT_WIDTH = DEF_RESULT_WIDTH,
    parameter int ACC_WIDTH    = DEF_ACC_WIDTH
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [VEC_LENGTH*DATA_WIDTH-1:0] in_weight,
    input  logic [VEC_LENGTH*DATA_WIDTH-1:0] in_act,
    output logic                             mac_en,
    output logic [VEC_LENGTH*DATA_WIDTH-1:0] mac_act,
    output logic [VEC_LENGTH-1:0]            mac_w_bit,
    output logic [COL_BITS-1:0]              mac_column_idx,
    output logic                             mac_is_msb,
    input  logic [RESULT_WIDTH-1:0]          mac_result,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [ACC_WIDTH-1:0]             out_data
);

    state_t                                 state_q, state_d;
    logic [COL_BITS-1:0]                    col_q, col_d;
    logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]  w_reg;
    logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]  act_reg;
    logic signed [ACC_WIDTH-1:0]            acc_q;
    logic                                   issued_d;
    logic                                   alive_q;
    logic                                   take;
    logic                                   issue_now;
    logic                                   last_col;
    logic [COL_BITS-1:0]                    next_col;
    logic [COL_BITS-1:0]                    start_col;

    // alive_q keeps in_ready low while reset is held and for the release cycle.
    assign take    = (state_q == IDLE) && alive_q && in_valid;
    assign mac_act = act_reg;

`ifdef ZERO_COLUMN_SKIP_EN
    logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] in_w;
    logic [NUM_COLS-1:0]                   in_mask;
    logic [NUM_COLS-1:0]                   mask_q;
    logic [COL_BITS-1:0]                   start_next;
    logic                                  start_none;
    logic                                  next_none;

    assign in_w = in_weight;

    // A bit column is non-zero when any lane has that weight bit set.
    always_comb begin
        in_mask = '0;
        for (int j = 0; j < VEC_LENGTH; j++) begin
            in_mask = in_mask | NUM_COLS'(in_w[j]);
        end
    end

    stripes_next_column u_start_col (
        .mask      (in_mask),
        .col       ('0),
        .next_col  (start_next),
        .none_left (start_none)
    );

    stripes_next_column u_next_col (
        .mask      (mask_q),
        .col       (col_q),
        .next_col  (next_col),
        .none_left (next_none)
    );

    // An all-zero vector parks on column 0 and leaves ISSUE without enabling the MAC.
    assign start_col = (in_mask[0] || start_none) ? '0 : start_next;
    assign issue_now = mask_q[col_q];
    assign last_col  = next_none;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mask_q <= '0;
        end else if (take) begin
            mask_q <= in_mask;
        end
    end
`else
    assign start_col = '0;
    assign issue_now = 1'b1;
    assign next_col  = col_q + 1'b1;
    assign last_col  = (col_q == COL_BITS'(NUM_COLS - 1));
`endif

    always_comb begin
        state_d        = state_q;
        col_d          = col_q;
        in_ready       = 1'b0;
        mac_en         = 1'b0;
        mac_w_bit      = '0;
        mac_column_idx = '0;
        mac_is_msb     = 1'b0;
        out_valid      = 1'b0;
        out_data       = '0;
        case (state_q)
            IDLE: begin
                in_ready = alive_q;
                if (take) begin
                    state_d = ISSUE;
                    col_d   = start_col;
                end
            end
            ISSUE: begin
                mac_en = issue_now;
                if (issue_now) begin
                    for (int j = 0; j < VEC_LENGTH; j++) begin
                        mac_w_bit[j] = w_reg[j][col_q];
                    end
                    mac_column_idx = col_q;
                    mac_is_msb     = (col_q == COL_BITS'(NUM_COLS - 1));
                end
                if (last_col) begin
                    state_d = DRAIN;
                end else begin
                    col_d = next_col;
                end
            end
            DRAIN: begin
                state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                out_data  = acc_q;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            col_q    <= '0;
            w_reg    <= '0;
            act_reg  <= '0;
            acc_q    <= '0;
            issued_d <= 1'b0;
            alive_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            issued_d <= mac_en;
            alive_q  <= 1'b1;
            if (take) begin
                w_reg   <= in_weight;
                act_reg <= in_act;
                acc_q   <= '0;
            end else if (issued_d) begin
                // The MAC has already applied column shift and sign weighting.
                acc_q <= acc_q + ACC_WIDTH'($signed(mac_result));
            end
        end
    end

endmodule

// File: tb/tb_stripes_bit_serial_feeder.sv
// Self-checking bench for stripes_bit_serial_feeder with a behavioural bit-serial MAC attached.
module tb_stripes_bit_serial_feeder;

    localparam int DW = 8;
    localparam int VL = 16;
    localparam int RW = 24;
    localparam int AW = 24;
    localparam int VW = VL * DW;
`ifdef ZERO_COLUMN_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [VW-1:0] in_weight;
    logic [VW-1:0] in_act;
    logic          mac_en;
    logic [VW-1:0] mac_act;
    logic [VL-1:0] mac_w_bit;
    logic [2:0]    mac_column_idx;
    logic          mac_is_msb;
    logic [RW-1:0] mac_result;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_data;

    stripes_bit_serial_feeder #(
        .DATA_WIDTH(DW), .VEC_LENGTH(VL), .RESULT_WIDTH(RW), .ACC_WIDTH(AW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_weight      (in_weight),
        .in_act         (in_act),
        .mac_en         (mac_en),
        .mac_act        (mac_act),
        .mac_w_bit      (mac_w_bit),
        .mac_column_idx (mac_column_idx),
        .mac_is_msb     (mac_is_msb),
        .mac_result     (mac_result),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];
    int sb_exp;

    typedef struct {
        logic [VW-1:0] w;
        logic [VW-1:0] a;
        int            exp;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_vec(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [VW-1:0] splat(input int v);
        logic [VW-1:0] r;
        for (int j = 0; j < VL; j++) r[j*DW +: DW] = DW'(v);
        return r;
    endfunction

    function automatic int dot(input logic [VW-1:0] w, input logic [VW-1:0] a);
        int s = 0;
        logic signed [DW-1:0] wj, aj;
        for (int j = 0; j < VL; j++) begin
            wj = w[j*DW +: DW];
            aj = a[j*DW +: DW];
            s += int'(wj) * int'(aj);
        end
        return s;
    endfunction

    function automatic logic [DW-1:0] col_mask(input logic [VW-1:0] w);
        logic [DW-1:0] m = '0;
        for (int j = 0; j < VL; j++) m |= w[j*DW +: DW];
        return m;
    endfunction

    // First column at or above start that the feeder is expected to issue; 8 when none.
    function automatic int next_issued(input logic [VW-1:0] w, input int start);
        logic [DW-1:0] m = col_mask(w);
        for (int c = start; c < 8; c++) begin
            if (!SKIP || m[c]) return c;
        end
        return 8;
    endfunction

    function automatic int n_issue(input logic [VW-1:0] w);
        int n = 0;
        for (int c = 0; c < 8; c++) if (next_issued(w, c) == c) n++;
        return n;
    endfunction

    // Behavioural MAC: one registered, shifted, sign-weighted column sum per enabled cycle.
    function automatic int col_val(input logic [VL-1:0] wb, input logic [VW-1:0] act,
                                   input logic [2:0] idx, input logic msb);
        int s = 0;
        logic signed [DW-1:0] aj;
        for (int j = 0; j < VL; j++) begin
            aj = act[j*DW +: DW];
            if (wb[j]) s += int'(aj);
        end
        s = s * (1 << idx);
        if (msb) s = -s;
        return s;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) mac_result <= '0;
        else if (mac_en) mac_result <= RW'(col_val(mac_w_bit, mac_act, mac_column_idx, mac_is_msb));
    end

    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out: got %0d expected no output", $signed(out_data));
            end else begin
                sb_exp = exp_q.pop_front();
                check("out_data", $signed(out_data), sb_exp);
            end
        end
    end

    task automatic wait_in_ready(input string name);
        int ok = 0;
        for (int k = 0; k < 40; k++) begin
            if (in_ready) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        check(name, ok, 1);
    endtask

    task automatic run_vec(input logic [VW-1:0] w, input logic [VW-1:0] a, input int exp);
        int en_cnt = 0;
        int lat = -1;
        int exp_col = next_issued(w, 0);
        int ni = n_issue(w);
        @(posedge clk); #1;
        in_weight = w;
        in_act    = a;
        in_valid  = 1'b1;
        wait_in_ready("accept_timeout");
        exp_q.push_back(exp);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (mac_en) begin
                check("column_idx", mac_column_idx, exp_col);
                check("is_msb", mac_is_msb, exp_col == 7);
                exp_col = next_issued(w, exp_col + 1);
                en_cnt++;
            end
            if (out_valid) begin
                lat = n;
                check_vec("mac_act_held", mac_act, a);
                break;
            end
        end
        check("en_cycles", en_cnt, ni);
        check("latency", lat, ((ni == 0) ? 1 : ni) + 1);
        @(posedge clk); #1;
    endtask

    initial begin
        int cnt;
        int ok;
        logic [VW-1:0] w_mix, a_r;

        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_weight = '0;
        in_act    = '0;

        for (int j = 0; j < VL; j++) w_mix[j*DW +: DW] = DW'(j - 8);
        tbl[0] = '{w: splat(1),    a: splat(1),    exp: 16};
        tbl[1] = '{w: splat(-128), a: splat(127),  exp: -260096};
        tbl[2] = '{w: splat(-1),   a: splat(-128), exp: 2048};
        tbl[3] = '{w: w_mix,       a: splat(3),    exp: -24};
        for (int j = 0; j < VL; j++) a_r[j*DW +: DW] = DW'($urandom_range(0, 255));
        tbl[4] = '{w: splat(0),    a: a_r,         exp: 0};
        for (int t = 5; t < 7; t++) begin
            for (int j = 0; j < VL; j++) begin
                tbl[t].w[j*DW +: DW] = DW'($urandom_range(0, 255));
                tbl[t].a[j*DW +: DW] = DW'($urandom_range(0, 255));
            end
            tbl[t].exp = dot(tbl[t].w, tbl[t].a);
        end

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_mac_en", mac_en, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("release_in_ready", in_ready, 0);
        @(posedge clk); #1;
        check("first_edge_in_ready", in_ready, 1);

        for (int t = 0; t < 7; t++) run_vec(tbl[t].w, tbl[t].a, tbl[t].exp);

        // Backpressure: result held, second vector waits for the output handshake.
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_weight = w_mix;
        in_act    = splat(3);
        in_valid  = 1'b1;
        wait_in_ready("bp_accept_timeout");
        exp_q.push_back(-24);
        @(posedge clk); #1;
        in_weight = splat(1);
        in_act    = splat(1);
        ok = 0;
        for (int k = 0; k < 40; k++) begin
            if (out_valid) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        check("bp_out_valid_timeout", ok, 1);
        for (int k = 0; k < 5; k++) begin
            check("bp_hold_data", $signed(out_data), -24);
            check("bp_hold_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_ready_after_handshake", in_ready, 1);
        exp_q.push_back(16);
        @(posedge clk); #1;
        in_valid = 1'b0;
        ok = 0;
        for (int k = 0; k < 40; k++) begin
            if (exp_q.size() == 0) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        check("bp_second_result", ok, 1);

        // Reset in the middle of ISSUE abandons the vector.
        @(posedge clk); #1;
        in_weight = splat(-1);
        in_act    = splat(-128);
        in_valid  = 1'b1;
        wait_in_ready("rst_accept_timeout");
        exp_q.push_back(2048);
        @(posedge clk); #1;
        in_valid = 1'b0;
        ok = 0;
        for (int k = 0; k < 20; k++) begin
            if (mac_en && mac_column_idx == 3'd3) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        check("reach_col3", ok, 1);
        reset = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_mac_en", mac_en, 0);
        check("mid_rst_w_bit", mac_w_bit, 0);
        check("mid_rst_col_idx", mac_column_idx, 0);
        check("mid_rst_is_msb", mac_is_msb, 0);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_data", out_data, 0);
        check_vec("mid_rst_mac_act", mac_act, '0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (out_valid) cnt++;
        end
        check("no_out_after_abandon", cnt, 0);
        run_vec(splat(-1), splat(-128), 2048);

        check("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
